// File: rtl/wm_ron_pkg.sv
// -----------------------------------------------------------------------------
// wm_ron_pkg
// Shared definitions for the RON master: request op encoding, command codes
// driven on ron_ctrl, and the master FSM state enum.
// Optional feature macro used by the importing files: WM_RESULT_CHECK_EN.
// -----------------------------------------------------------------------------
package wm_ron_pkg;

  // Request op encoding on req_op
  typedef enum logic [1:0] {
    OP_DEC1 = 2'b00,
    OP_INC2 = 2'b01,
    OP_INV  = 2'b10,
    OP_ILL  = 2'b11
  } op_e;

  // Command codes on ron_ctrl
  localparam logic [2:0] CTRL_IDLE = 3'b000;
  localparam logic [2:0] CTRL_DEC1 = 3'b001;
  localparam logic [2:0] CTRL_INC2 = 3'b010;
  localparam logic [2:0] CTRL_INV  = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_CAPT  = 2'b10,
    ST_RESP  = 2'b11
  } state_e;

  // Map a request op to the unit command; the illegal op never issues.
  function automatic logic [2:0] ctrl_code(input op_e op);
    logic [2:0] code;
    case (op)
      OP_DEC1: code = CTRL_DEC1;
      OP_INC2: code = CTRL_INC2;
      OP_INV:  code = CTRL_INV;
      default: code = CTRL_IDLE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/wm_ron_expect.sv
// -----------------------------------------------------------------------------
// wm_ron_expect
// Purely combinational reference of the processing unit: computes the result
// the unit should return for (op, data), 8-bit modulo arithmetic.
// Ports:
//   op_i   - latched request op
//   data_i - latched operand
//   exp_o  - expected unit result
// -----------------------------------------------------------------------------
module wm_ron_expect
  import wm_ron_pkg::*;
(
  input  op_e        op_i,
  input  logic [7:0] data_i,
  output logic [7:0] exp_o
);

  always_comb begin
    exp_o = data_i;
    case (op_i)
      OP_DEC1: exp_o = data_i - 8'd1;
      OP_INC2: exp_o = data_i + 8'd2;
      OP_INV:  exp_o = ~data_i;
      default: exp_o = data_i;
    endcase
  end

endmodule

// File: rtl/wm_ron_master.sv
// -----------------------------------------------------------------------------
// wm_ron_master
// Single-outstanding request/response master for a RON processing unit.
// Accepts one request in IDLE, issues a one-cycle command to the unit, captures
// the unit's registered result one cycle later and presents it downstream,
// holding it until rsp_ready. Illegal ops are answered with rsp_err and no
// command.
// Optional feature: define WM_RESULT_CHECK_EN to compare the unit result with
// a locally computed expectation (wm_ron_expect) and count mismatches.
// Ports:
//   clk, rst                   - clock, synchronous active-high reset
//   req_valid/req_ready        - request handshake, req_op / req_data payload
//   rsp_valid/rsp_ready        - response handshake, rsp_data / rsp_err payload
//   ron_ctrl, ron_data_in      - command and operand to the unit
//   ron_data_out, ron_status   - unit result (1-cycle latency) and status
//   txn_count, mismatch_cnt    - saturating completion / mismatch counters
// -----------------------------------------------------------------------------
module wm_ron_master
  import wm_ron_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [7:0]       req_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_data,
  output logic             rsp_err,
  output logic [2:0]       ron_ctrl,
  output logic [7:0]       ron_data_in,
  input  logic [7:0]       ron_data_out,
  input  logic [7:0]       ron_status,
  output logic [CNT_W-1:0] txn_count,
  output logic [CNT_W-1:0] mismatch_cnt
);

  state_e           state_q, state_d;
  op_e              op_q;
  logic [7:0]       opd_q;
  logic [7:0]       rsp_data_q;
  logic             rsp_err_q;
  logic [CNT_W-1:0] txn_q, txn_d;
  logic             accept;
  logic             unit_held;
  logic             rsp_done;
  logic             mismatch;
  logic             unused_status;

  // Only bit1 of the unit status matters to this master.
  assign unused_status = ^{ron_status[7:2], ron_status[0]};
  assign unit_held     = ron_status[1];
  assign accept        = req_valid && req_ready;
  assign rsp_done      = (state_q == ST_RESP) && rsp_ready;

`ifdef WM_RESULT_CHECK_EN
  logic [7:0]       exp_res;
  logic [CNT_W-1:0] mm_q, mm_d;

  wm_ron_expect u_expect (
    .op_i   (op_q),
    .data_i (opd_q),
    .exp_o  (exp_res)
  );

  assign mismatch = (ron_data_out != exp_res);

  always_comb begin
    mm_d = mm_q;
    if (state_q == ST_CAPT && mismatch && mm_q != '1) mm_d = mm_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) mm_q <= '0;
    else     mm_q <= mm_d;
  end

  assign mismatch_cnt = mm_q;
`else
  assign mismatch     = 1'b0;
  assign mismatch_cnt = '0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = (op_e'(req_op) == OP_ILL) ? ST_RESP : ST_ISSUE;
      ST_ISSUE: if (!unit_held) state_d = ST_CAPT;
      ST_CAPT:  state_d = ST_RESP;
      ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output logic; req_ready is also gated by rst so it reads 0 while reset is held.
  always_comb begin
    req_ready   = (state_q == ST_IDLE) && !rst;
    rsp_valid   = (state_q == ST_RESP);
    ron_ctrl    = CTRL_IDLE;
    ron_data_in = 8'h00;
    if (state_q == ST_ISSUE) begin
      ron_data_in = opd_q;
      if (!unit_held) ron_ctrl = ctrl_code(op_q);
    end
  end

  always_comb begin
    txn_d = txn_q;
    if (rsp_done && txn_q != '1) txn_d = txn_q + CNT_W'(1);
  end

  // Request latch, response capture and completion counter
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= OP_DEC1;
      opd_q      <= 8'h00;
      rsp_data_q <= 8'h00;
      rsp_err_q  <= 1'b0;
      txn_q      <= '0;
    end else begin
      txn_q <= txn_d;
      if (state_q == ST_IDLE && accept) begin
        op_q  <= op_e'(req_op);
        opd_q <= req_data;
        if (op_e'(req_op) == OP_ILL) begin
          rsp_data_q <= 8'h00;
          rsp_err_q  <= 1'b1;
        end
      end else if (state_q == ST_CAPT) begin
        rsp_data_q <= ron_data_out;
        rsp_err_q  <= mismatch;
      end
    end
  end

  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign txn_count = txn_q;

endmodule

// File: tb/tb_wm_ron_master.sv
module tb_wm_ron_master;

  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [1:0]       req_op = 2'b00;
  logic [7:0]       req_data = 8'h00;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic [7:0]       rsp_data;
  logic             rsp_err;
  logic [2:0]       ron_ctrl;
  logic [7:0]       ron_data_in;
  logic [7:0]       ron_data_out = 8'h00;
  logic [7:0]       ron_status = 8'h00;
  logic [CNT_W-1:0] txn_count;
  logic [CNT_W-1:0] mismatch_cnt;

  int checks = 0;
  int errors = 0;
  int exp_txn = 0;
  logic fault_en = 1'b0;
  logic [7:0] unit_res;

  wm_ron_master #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_data     (req_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .ron_ctrl     (ron_ctrl),
    .ron_data_in  (ron_data_in),
    .ron_data_out (ron_data_out),
    .ron_status   (ron_status),
    .txn_count    (txn_count),
    .mismatch_cnt (mismatch_cnt)
  );

  always #5 clk = ~clk;

  // Processing unit: registered result, one-cycle latency; fault_en skews it.
  always_comb begin
    unit_res = ron_data_in;
    case (ron_ctrl)
      3'b001:  unit_res = ron_data_in - 8'd1;
      3'b010:  unit_res = ron_data_in + 8'd2;
      3'b011:  unit_res = ~ron_data_in;
      default: unit_res = ron_data_in;
    endcase
    if (fault_en) unit_res = unit_res - 8'd1;
  end

  always @(posedge clk) if (ron_ctrl != 3'b000) ron_data_out <= unit_res;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic bump_txn;
    exp_txn = (exp_txn == (1 << CNT_W) - 1) ? exp_txn : exp_txn + 1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if ({rsp_data, rsp_err} !== 9'h000) begin errors++; $display("FAIL rst_rsp: got %h/%b want 00/0", rsp_data, rsp_err); end
    checks++; if ({ron_ctrl, ron_data_in} !== 11'h000) begin errors++; $display("FAIL rst_ron: got %b/%h want 000/00", ron_ctrl, ron_data_in); end
    checks++; if ({txn_count, mismatch_cnt} !== '0) begin errors++; $display("FAIL rst_counters: got %0d/%0d want 0/0", txn_count, mismatch_cnt); end
    rst = 1'b0;
    tick();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_dec1;
    rsp_ready = 1'b1; req_op = 2'b00; req_data = 8'h05; req_valid = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL dec1_accept_ready: got %b want 1", req_ready); end
    tick();
    req_valid = 1'b0; req_data = 8'h00;
    checks++; if (ron_ctrl !== 3'b001 || ron_data_in !== 8'h05) begin errors++; $display("FAIL dec1_issue: got %b/%h want 001/05", ron_ctrl, ron_data_in); end
    checks++; if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL dec1_issue_hs: got ready %b valid %b want 0/0", req_ready, rsp_valid); end
    tick();
    checks++; if (ron_ctrl !== 3'b000 || ron_data_in !== 8'h00 || rsp_valid !== 1'b0) begin errors++; $display("FAIL dec1_capt: got %b/%h/%b want 000/00/0", ron_ctrl, ron_data_in, rsp_valid); end
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h04 || rsp_err !== 1'b0) begin errors++; $display("FAIL dec1_resp: got %b/%h/%b want 1/04/0", rsp_valid, rsp_data, rsp_err); end
    tick();
    bump_txn();
    checks++; if (txn_count !== CNT_W'(exp_txn) || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL dec1_done: got txn %0d valid %b ready %b want %0d/0/1", txn_count, rsp_valid, req_ready, exp_txn); end
  endtask

  task automatic run_legal(input logic [1:0] op, input logic [7:0] din, input logic [2:0] exp_ctrl, input logic [7:0] exp_data, input string name);
    rsp_ready = 1'b1; req_op = op; req_data = din; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    checks++; if (ron_ctrl !== exp_ctrl || ron_data_in !== din) begin errors++; $display("FAIL %s_issue: got %b/%h want %b/%h", name, ron_ctrl, ron_data_in, exp_ctrl, din); end
    tick();
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== exp_data || rsp_err !== 1'b0) begin errors++; $display("FAIL %s_resp: got %b/%h/%b want 1/%h/0", name, rsp_valid, rsp_data, rsp_err, exp_data); end
    tick();
    bump_txn();
    checks++; if (txn_count !== CNT_W'(exp_txn)) begin errors++; $display("FAIL %s_txn: got %0d want %0d", name, txn_count, exp_txn); end
  endtask

  task automatic test_modulo;
    run_legal(2'b01, 8'hFE, 3'b010, 8'h00, "inc2_fe");
    run_legal(2'b10, 8'h5A, 3'b011, 8'hA5, "inv_5a");
    run_legal(2'b01, 8'hFF, 3'b010, 8'h01, "inc2_ff");
    run_legal(2'b00, 8'h00, 3'b001, 8'hFF, "dec1_00");
    checks++; if (mismatch_cnt !== '0) begin errors++; $display("FAIL modulo_mismatch_cnt: got %0d want 0", mismatch_cnt); end
  endtask

  task automatic test_illegal;
    rsp_ready = 1'b1; req_op = 2'b11; req_data = 8'h77; req_valid = 1'b1;
    #1;
    checks++; if (ron_ctrl !== 3'b000) begin errors++; $display("FAIL ill_accept_ctrl: got %b want 000", ron_ctrl); end
    tick();
    req_valid = 1'b0;
    checks++; if (ron_ctrl !== 3'b000 || ron_data_in !== 8'h00) begin errors++; $display("FAIL ill_ctrl: got %b/%h want 000/00", ron_ctrl, ron_data_in); end
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h00 || rsp_err !== 1'b1) begin errors++; $display("FAIL ill_resp: got %b/%h/%b want 1/00/1", rsp_valid, rsp_data, rsp_err); end
    tick();
    bump_txn();
    checks++; if (txn_count !== CNT_W'(exp_txn) || rsp_valid !== 1'b0) begin errors++; $display("FAIL ill_done: got txn %0d valid %b want %0d/0", txn_count, rsp_valid, exp_txn); end
  endtask

  task automatic test_stall;
    int issued = 0;
    int lat = 0;
    rsp_ready = 1'b1; ron_status = 8'h02; req_op = 2'b01; req_data = 8'h30; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      lat++;
      if (ron_ctrl != 3'b000) issued++;
      checks++; if (ron_ctrl !== 3'b000 || rsp_valid !== 1'b0) begin errors++; $display("FAIL stall_hold%0d: got ctrl %b valid %b want 000/0", i, ron_ctrl, rsp_valid); end
      tick();
    end
    ron_status = 8'h00;
    #1;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      lat++;
      if (ron_ctrl != 3'b000) issued++;
      tick();
    end
    checks++; if (issued !== 1) begin errors++; $display("FAIL stall_issue_count: got %0d want 1", issued); end
    checks++; if (lat + 1 !== 7) begin errors++; $display("FAIL stall_latency: got N+%0d want N+7", lat + 1); end
    checks++; if (rsp_data !== 8'h32 || rsp_err !== 1'b0) begin errors++; $display("FAIL stall_resp: got %h/%b want 32/0", rsp_data, rsp_err); end
    tick();
    bump_txn();
    checks++; if (txn_count !== CNT_W'(exp_txn)) begin errors++; $display("FAIL stall_txn: got %0d want %0d", txn_count, exp_txn); end
  endtask

`ifdef WM_RESULT_CHECK_EN
  task automatic test_mismatch;
    fault_en = 1'b1; rsp_ready = 1'b1; req_op = 2'b01; req_data = 8'h10; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    fault_en = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h11 || rsp_err !== 1'b1) begin errors++; $display("FAIL mm_resp: got %b/%h/%b want 1/11/1", rsp_valid, rsp_data, rsp_err); end
    checks++; if (mismatch_cnt !== CNT_W'(1)) begin errors++; $display("FAIL mm_cnt: got %0d want 1", mismatch_cnt); end
    tick();
    bump_txn();
  endtask
`endif

  task automatic test_back_pressure;
    rsp_ready = 1'b0; req_op = 2'b10; req_data = 8'h0F; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'hF0 || rsp_err !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL bp_hold%0d: got %b/%h/%b ready %b want 1/f0/0 ready 0", i, rsp_valid, rsp_data, rsp_err, req_ready); end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    bump_txn();
    checks++; if (rsp_valid !== 1'b0 || txn_count !== CNT_W'(exp_txn)) begin errors++; $display("FAIL bp_done_sat: got valid %b txn %0d want 0/%0d", rsp_valid, txn_count, exp_txn); end
  endtask

  task automatic test_rst_mid;
    int seen = 0;
    rsp_ready = 1'b1; req_op = 2'b00; req_data = 8'h40; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    exp_txn = 0;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || ron_ctrl !== 3'b000) begin errors++; $display("FAIL rmid_state: got valid %b ready %b ctrl %b want 0/0/000", rsp_valid, req_ready, ron_ctrl); end
    checks++; if (txn_count !== '0 || mismatch_cnt !== '0) begin errors++; $display("FAIL rmid_counters: got %0d/%0d want 0/0", txn_count, mismatch_cnt); end
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %b want 1", req_ready); end
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid !== 1'b0) seen++;
      tick();
    end
    checks++; if (seen !== 0 || txn_count !== '0) begin errors++; $display("FAIL rmid_no_resp: got %0d responses txn %0d want 0/0", seen, txn_count); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_dec1();
    test_modulo();
    test_illegal();
    test_stall();
`ifdef WM_RESULT_CHECK_EN
    test_mismatch();
`endif
    test_back_pressure();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
